// File: rtl/cp0_vec_pkg.sv
// Shared constants for the CP0 status/cause/EPC/PRId register block.
// Select codes, bit positions of the SR/Cause fields and the default processor ID.
package cp0_vec_pkg;

   localparam logic [4:0] SEL_SR    = 5'd12;
   localparam logic [4:0] SEL_CAUSE = 5'd13;
   localparam logic [4:0] SEL_EPC   = 5'd14;
   localparam logic [4:0] SEL_PRID  = 5'd15;

   localparam int IP_BASE = 10;
   localparam int IM_BASE = 10;
   localparam int EXL_BIT = 1;
   localparam int IE_BIT  = 0;

   localparam logic [31:0] PRID_DEFAULT = 32'h0000_0017;

endpackage

// File: rtl/cp0_vec_if.sv
// Bundle of CP0 datapath/control signals between the pipeline controller and cp0_vec.
// The master drives interrupt lines, PC, write data and strobes; the slave returns status.
interface cp0_vec_if #(
   parameter int NINT = 6
);
   logic [NINT-1:0] hw_int;
   logic [29:0]     pc;
   logic [31:0]     din;
   logic [4:0]      sel;
   logic            wen;
   logic            epc_wr;
   logic            exl_set;
   logic            exl_clr;
   logic            int_req;
   logic [3:0]      int_id;
   logic [29:0]     epc;
   logic [31:0]     dout;

   modport slave (
      input  hw_int, pc, din, sel, wen, epc_wr, exl_set, exl_clr,
      output int_req, int_id, epc, dout
   );

   modport master (
      output hw_int, pc, din, sel, wen, epc_wr, exl_set, exl_clr,
      input  int_req, int_id, epc, dout
   );
endinterface

// File: rtl/cp0_vec_prio.sv
// Fixed-priority encoder: lowest set index wins; idx is 0 when nothing is set.
module cp0_vec_prio #(
   parameter int NINT = 6
) (
   input  logic [NINT-1:0] req,
   output logic            any,
   output logic [3:0]      idx
);

   always_comb begin
      any = |req;
      idx = 4'd0;
      // Scan downward so the lowest pending index is the last assignment.
      for (int i = NINT - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = 4'(i);
         end
      end
   end

endmodule

// File: rtl/cp0_vec.sv
// CP0 register block: SR, Cause, EPC, PRId with vectored interrupt request/ID.
// Define CP0_VEC_STICKY_EN to make Cause.IP sticky with write-one-to-clear.
module cp0_vec
   import cp0_vec_pkg::*;
#(
   parameter int          NINT = 6,
   parameter logic [31:0] PRID = PRID_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   cp0_vec_if.slave    bus
);

   logic [NINT-1:0] im_q, im_d;
   logic [NINT-1:0] ip_q, ip_d;
   logic            ie_q, ie_d;
   logic            exl_q, exl_d;
   logic [29:0]     epc_q, epc_d;

   logic            wr_sr;
   logic            wr_cause;
   logic            wr_epc;
   logic            pend_any;
   logic [3:0]      pend_idx;

   assign wr_sr    = bus.wen && (bus.sel == SEL_SR);
   assign wr_cause = bus.wen && (bus.sel == SEL_CAUSE);
   assign wr_epc   = bus.wen && (bus.sel == SEL_EPC);

   always_comb begin
      im_d  = im_q;
      ie_d  = ie_q;
      exl_d = exl_q;
      epc_d = epc_q;

      if (wr_sr) begin
         im_d  = bus.din[IM_BASE +: NINT];
         ie_d  = bus.din[IE_BIT];
         exl_d = bus.din[EXL_BIT];
      end

      // Exception entry/return strobes override only the EXL bit of an SR write.
      if (bus.exl_set) begin
         exl_d = 1'b1;
      end else if (bus.exl_clr) begin
         exl_d = 1'b0;
      end

      if (bus.epc_wr) begin
         epc_d = bus.pc;
      end else if (wr_epc) begin
         epc_d = bus.din[31:2];
      end
   end

   generate
      for (genvar gi = 0; gi < NINT; gi++) begin : g_ip
`ifdef CP0_VEC_STICKY_EN
         // A live request beats a same-cycle software clear.
         assign ip_d[gi] = bus.hw_int[gi] |
                           (ip_q[gi] & ~(wr_cause & bus.din[IP_BASE + gi]));
`else
         assign ip_d[gi] = bus.hw_int[gi];
`endif
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         im_q  <= '0;
         ip_q  <= '0;
         ie_q  <= 1'b0;
         exl_q <= 1'b0;
         epc_q <= '0;
      end else begin
         im_q  <= im_d;
         ip_q  <= ip_d;
         ie_q  <= ie_d;
         exl_q <= exl_d;
         epc_q <= epc_d;
      end
   end

   cp0_vec_prio #(
      .NINT (NINT)
   ) u_prio (
      .req (ip_q & im_q),
      .any (pend_any),
      .idx (pend_idx)
   );

   assign bus.int_req = pend_any & ie_q & ~exl_q;
   assign bus.int_id  = pend_idx;
   assign bus.epc     = epc_q;

   always_comb begin
      bus.dout = 32'd0;
      case (bus.sel)
         SEL_SR: begin
            bus.dout[IM_BASE +: NINT] = im_q;
            bus.dout[EXL_BIT]         = exl_q;
            bus.dout[IE_BIT]          = ie_q;
         end
         SEL_CAUSE: bus.dout[IP_BASE +: NINT] = ip_q;
         SEL_EPC:   bus.dout = {epc_q, 2'b00};
         SEL_PRID:  bus.dout = PRID;
         default:   bus.dout = 32'd0;
      endcase
   end

endmodule
